// File: rtl/icache_linefill_if.sv
// Refill-beat, MSHR-lookup, RAM-write and completion signals of the icache linefill controller.
// The master modport is the controller side; the slave modport is its environment.
interface icache_linefill_if #(
  parameter int unsigned ENTRY_IDX_W = 3,
  parameter int unsigned LINE_BEATS  = 4,
  parameter int unsigned BEAT_W      = 128,
  parameter int unsigned INDEX_W     = 7,
  parameter int unsigned TAG_W       = 20
);
  logic                         rxdat_vld;
  logic                         rxdat_rdy;
  logic [ENTRY_IDX_W-1:0]       rxdat_entry_id;
  logic [BEAT_W-1:0]            rxdat_data;
  logic                         rxdat_err;
  logic [ENTRY_IDX_W-1:0]       lkp_entry_id;
  logic [INDEX_W-1:0]           lkp_index;
  logic                         lkp_way;
  logic [TAG_W-1:0]             lkp_tag;
  logic                         ram_wr_vld;
  logic                         ram_wr_rdy;
  logic                         ram_wr_way;
  logic [INDEX_W-1:0]           ram_wr_index;
  logic [TAG_W-1:0]             ram_wr_tag;
  logic [LINE_BEATS*BEAT_W-1:0] ram_wr_data;
  logic                         linefill_done;
  logic [ENTRY_IDX_W:0]         linefill_ack_entry_idx;
  logic                         linefill_err;

  modport master (
    input  rxdat_vld, rxdat_entry_id, rxdat_data, rxdat_err,
    input  lkp_index, lkp_way, lkp_tag, ram_wr_rdy,
    output rxdat_rdy, lkp_entry_id,
    output ram_wr_vld, ram_wr_way, ram_wr_index, ram_wr_tag, ram_wr_data,
    output linefill_done, linefill_ack_entry_idx, linefill_err
  );

  modport slave (
    output rxdat_vld, rxdat_entry_id, rxdat_data, rxdat_err,
    output lkp_index, lkp_way, lkp_tag, ram_wr_rdy,
    input  rxdat_rdy, lkp_entry_id,
    input  ram_wr_vld, ram_wr_way, ram_wr_index, ram_wr_tag, ram_wr_data,
    input  linefill_done, linefill_ack_entry_idx, linefill_err
  );
endinterface

// File: rtl/icache_linefill_ctrl.sv
// Assembles refill beats into a full icache line, writes data+tag RAM at the owning MSHR's
// way/index, then pulses linefill_done (with linefill_err for errored lines, which skip the write).
module icache_linefill_ctrl #(
  parameter int unsigned ENTRY_IDX_W = 3,
  parameter int unsigned LINE_BEATS  = 4,
  parameter int unsigned BEAT_W      = 128,
  parameter int unsigned INDEX_W     = 7,
  parameter int unsigned TAG_W       = 20
) (
  input logic               clk,
  input logic               rst,
  icache_linefill_if.master bus
);
  localparam int unsigned      CNT_W     = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   err_sticky;
  logic [ENTRY_IDX_W-1:0] entry_id;
  logic [BEAT_W-1:0]      beat_buf [LINE_BEATS];

  logic                   rdy_q;
  logic                   wr_vld_q;
  logic                   wr_way_q;
  logic [INDEX_W-1:0]     wr_index_q;
  logic [TAG_W-1:0]       wr_tag_q;
  logic                   done_q;
  logic [ENTRY_IDX_W:0]   ack_q;
  logic                   lf_err_q;

  logic                   beat_acc;
  logic                   line_err;

  assign beat_acc = bus.rxdat_vld & rdy_q;
  assign line_err = err_sticky | bus.rxdat_err;

  // Line buffer is deliberately not reset; every slot is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    if (beat_acc) beat_buf[beat_cnt] <= bus.rxdat_data;
  end

  // Linefill sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      err_sticky <= 1'b0;
      entry_id   <= '0;
      rdy_q      <= 1'b1;
      wr_vld_q   <= 1'b0;
      wr_way_q   <= 1'b0;
      wr_index_q <= '0;
      wr_tag_q   <= '0;
      done_q     <= 1'b0;
      ack_q      <= '0;
      lf_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_acc) begin
            entry_id   <= bus.rxdat_entry_id;
            beat_cnt   <= CNT_W'(1);
            err_sticky <= bus.rxdat_err;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_acc) begin
            beat_cnt   <= beat_cnt + CNT_W'(1);
            err_sticky <= line_err;
            if (beat_cnt == LAST_BEAT) begin
              wr_way_q   <= bus.lkp_way;
              wr_index_q <= bus.lkp_index;
              wr_tag_q   <= bus.lkp_tag;
              rdy_q      <= 1'b0;
              if (line_err) begin
                done_q   <= 1'b1;
                ack_q    <= {1'b0, entry_id};
                lf_err_q <= 1'b1;
                state    <= DONE;
              end else begin
                wr_vld_q <= 1'b1;
                state    <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (bus.ram_wr_rdy) begin
            wr_vld_q <= 1'b0;
            done_q   <= 1'b1;
            ack_q    <= {1'b0, entry_id};
            lf_err_q <= err_sticky;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          ack_q      <= '0;
          lf_err_q   <= 1'b0;
          err_sticky <= 1'b0;
          rdy_q      <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rxdat_rdy              = rdy_q;
  assign bus.lkp_entry_id           = entry_id;
  assign bus.ram_wr_vld             = wr_vld_q;
  assign bus.ram_wr_way             = wr_way_q;
  assign bus.ram_wr_index           = wr_index_q;
  assign bus.ram_wr_tag             = wr_tag_q;
  assign bus.linefill_done          = done_q;
  assign bus.linefill_ack_entry_idx = ack_q;
  assign bus.linefill_err           = lf_err_q;

  // Beat 0 occupies the least significant bits of the written line.
  for (genvar b = 0; b < LINE_BEATS; b++) begin : g_pack
    assign bus.ram_wr_data[b*BEAT_W +: BEAT_W] = beat_buf[b];
  end

`ifndef SYNTHESIS
  a_entry_stable: assert property (@(posedge clk) disable iff (rst)
    (state == COLLECT && beat_acc) |-> (bus.rxdat_entry_id == entry_id));
`endif
endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Self-checking bench for icache_linefill_ctrl: directed scenarios plus randomized lines
// compared against a line-level reference model.
module tb_icache_linefill_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   passed;
  int   total;

  icache_linefill_if ifc ();

  icache_linefill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MSHR file model: index/way/tag recorded per entry, returned combinationally.
  logic [6:0]  m_index [8];
  logic        m_way   [8];
  logic [19:0] m_tag   [8];
  assign ifc.lkp_index = m_index[ifc.lkp_entry_id];
  assign ifc.lkp_way   = m_way[ifc.lkp_entry_id];
  assign ifc.lkp_tag   = m_tag[ifc.lkp_entry_id];

  // Reference lines: entry id, beats and per-beat error flags.
  logic [2:0]   lid [2];
  logic [127:0] ld  [2][4];
  bit           le  [2][4];

  function automatic logic [511:0] model_line(input int ln);
    logic [511:0] l;
    l = '0;
    for (int b = 3; b >= 0; b--) l = {l[383:0], ld[ln][b]};
    return l;
  endfunction

  function automatic bit model_err(input int ln);
    return le[ln][0] | le[ln][1] | le[ln][2] | le[ln][3];
  endfunction

  function automatic logic [127:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_line(input int ln, input bit with_err);
    lid[ln] = 3'($urandom_range(0, 7));
    for (int b = 0; b < 4; b++) begin
      ld[ln][b] = rand_beat();
      le[ln][b] = with_err ? ($urandom_range(0, 4) == 0) : 1'b0;
    end
  endtask

  // Drives one line; returns just after the accepting edge of the last beat.
  task automatic send_line(input int ln, input bit gaps, input bit keep, output int first_cyc);
    first_cyc = 0;
    for (int b = 0; b < 4; b++) begin
      int waitc;
      waitc = 0;
      if (gaps && b > 0) begin
        ifc.rxdat_data = rand_beat();
        @(negedge clk);
      end
      @(negedge clk);
      ifc.rxdat_vld      = 1'b1;
      ifc.rxdat_entry_id = lid[ln];
      ifc.rxdat_data     = ld[ln][b];
      ifc.rxdat_err      = le[ln][b];
      while (ifc.rxdat_rdy !== 1'b1 && waitc < 40) begin
        @(negedge clk);
        waitc++;
      end
      total++;
      if (ifc.rxdat_rdy !== 1'b1)
        $display("FAIL beat_accept line %0d beat %0d: rdy=%b, required 1 within 40 cycles", ln, b, ifc.rxdat_rdy);
      else passed++;
      @(posedge clk);
      #1;
      if (b == 0) first_cyc = cyc;
      if (gaps || (b == 3 && !keep)) ifc.rxdat_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ifc.rxdat_rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", ifc.rxdat_rdy); else passed++;
    total++; if (ifc.ram_wr_vld !== 1'b0) $display("FAIL reset_wr_vld got %b exp 0", ifc.ram_wr_vld); else passed++;
    total++; if (ifc.linefill_done !== 1'b0) $display("FAIL reset_done got %b exp 0", ifc.linefill_done); else passed++;
    total++; if (ifc.linefill_err !== 1'b0) $display("FAIL reset_err got %b exp 0", ifc.linefill_err); else passed++;
    total++; if (ifc.linefill_ack_entry_idx !== 4'd0) $display("FAIL reset_ack got %h exp 0", ifc.linefill_ack_entry_idx); else passed++;
    total++; if (ifc.lkp_entry_id !== 3'd0) $display("FAIL reset_lkp_id got %h exp 0", ifc.lkp_entry_id); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_line();
    int fc;
    lid[0] = 3'd5;
    ld[0][0] = {16{8'h11}}; ld[0][1] = {16{8'h22}};
    ld[0][2] = {16{8'h33}}; ld[0][3] = {16{8'h44}};
    for (int b = 0; b < 4; b++) le[0][b] = 1'b0;
    ifc.ram_wr_rdy = 1'b1;
    send_line(0, 1'b0, 1'b0, fc);
    total++; if (ifc.ram_wr_vld !== 1'b1) $display("FAIL clean_wr_vld got %b exp 1", ifc.ram_wr_vld); else passed++;
    total++; if (ifc.ram_wr_data !== model_line(0)) $display("FAIL clean_data got %h exp %h", ifc.ram_wr_data, model_line(0)); else passed++;
    total++; if (ifc.ram_wr_index !== m_index[5]) $display("FAIL clean_index got %h exp %h", ifc.ram_wr_index, m_index[5]); else passed++;
    total++; if (ifc.ram_wr_way !== m_way[5]) $display("FAIL clean_way got %b exp %b", ifc.ram_wr_way, m_way[5]); else passed++;
    total++; if (ifc.ram_wr_tag !== m_tag[5]) $display("FAIL clean_tag got %h exp %h", ifc.ram_wr_tag, m_tag[5]); else passed++;
    total++; if (ifc.lkp_entry_id !== 3'd5) $display("FAIL clean_lkp_id got %h exp 5", ifc.lkp_entry_id); else passed++;
    total++; if (ifc.rxdat_rdy !== 1'b0) $display("FAIL clean_rdy_in_write got %b exp 0", ifc.rxdat_rdy); else passed++;
    @(posedge clk); #1;
    total++; if (ifc.linefill_done !== 1'b1) $display("FAIL clean_done got %b exp 1", ifc.linefill_done); else passed++;
    total++; if (ifc.linefill_ack_entry_idx !== 4'b0101) $display("FAIL clean_ack got %b exp 0101", ifc.linefill_ack_entry_idx); else passed++;
    total++; if (ifc.linefill_err !== 1'b0) $display("FAIL clean_err got %b exp 0", ifc.linefill_err); else passed++;
    total++; if (ifc.ram_wr_vld !== 1'b0) $display("FAIL clean_wr_vld_drop got %b exp 0", ifc.ram_wr_vld); else passed++;
    @(posedge clk); #1;
    total++; if (ifc.linefill_done !== 1'b0) $display("FAIL clean_done_one_cycle got %b exp 0", ifc.linefill_done); else passed++;
    total++; if (ifc.rxdat_rdy !== 1'b1) $display("FAIL clean_rdy_idle got %b exp 1", ifc.rxdat_rdy); else passed++;
  endtask

  task automatic test_write_stall();
    int fc;
    rand_line(0, 1'b0);
    ifc.ram_wr_rdy = 1'b0;
    send_line(0, 1'b0, 1'b0, fc);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      total++; if (ifc.ram_wr_vld !== 1'b1) $display("FAIL stall_wr_vld cyc %0d got %b exp 1", k, ifc.ram_wr_vld); else passed++;
      total++; if (ifc.ram_wr_data !== model_line(0) || ifc.ram_wr_index !== m_index[lid[0]] || ifc.ram_wr_tag !== m_tag[lid[0]])
        $display("FAIL stall_stable cyc %0d got idx %h tag %h exp idx %h tag %h (or data)", k, ifc.ram_wr_index, ifc.ram_wr_tag, m_index[lid[0]], m_tag[lid[0]]);
      else passed++;
      total++; if (ifc.linefill_done !== 1'b0) $display("FAIL stall_early_done cyc %0d got %b exp 0", k, ifc.linefill_done); else passed++;
      if (k == 3) ifc.ram_wr_rdy = 1'b1;
    end
    @(posedge clk); #1;
    total++; if (ifc.linefill_done !== 1'b1) $display("FAIL stall_done got %b exp 1", ifc.linefill_done); else passed++;
    total++; if (ifc.linefill_ack_entry_idx !== {1'b0, lid[0]}) $display("FAIL stall_ack got %h exp %h", ifc.linefill_ack_entry_idx, {1'b0, lid[0]}); else passed++;
    @(posedge clk); #1;
    total++; if (ifc.linefill_done !== 1'b0) $display("FAIL stall_done_one_cycle got %b exp 0", ifc.linefill_done); else passed++;
  endtask

  task automatic test_error_line();
    int fc;
    rand_line(0, 1'b0);
    lid[0] = 3'd2;
    le[0][2] = 1'b1;
    ifc.ram_wr_rdy = 1'b1;
    send_line(0, 1'b0, 1'b0, fc);
    total++; if (ifc.ram_wr_vld !== 1'b0) $display("FAIL err_no_write got %b exp 0", ifc.ram_wr_vld); else passed++;
    total++; if (ifc.linefill_done !== 1'b1) $display("FAIL err_done got %b exp 1", ifc.linefill_done); else passed++;
    total++; if (ifc.linefill_err !== 1'b1) $display("FAIL err_flag got %b exp 1", ifc.linefill_err); else passed++;
    total++; if (ifc.linefill_ack_entry_idx !== 4'd2) $display("FAIL err_ack got %h exp 2", ifc.linefill_ack_entry_idx); else passed++;
    @(posedge clk); #1;
    total++; if (ifc.ram_wr_vld !== 1'b0 || ifc.linefill_done !== 1'b0)
      $display("FAIL err_after got vld %b done %b exp 0 0", ifc.ram_wr_vld, ifc.linefill_done); else passed++;
  endtask

  task automatic test_back_to_back();
    int fc0, fc1, done_cyc;
    rand_line(0, 1'b0); rand_line(1, 1'b0);
    lid[0] = 3'd1; lid[1] = 3'd6;
    ifc.ram_wr_rdy = 1'b1;
    send_line(0, 1'b0, 1'b1, fc0);
    ifc.rxdat_entry_id = lid[1];
    ifc.rxdat_data     = ld[1][0];
    ifc.rxdat_err      = 1'b0;
    total++; if (ifc.ram_wr_data !== model_line(0)) $display("FAIL b2b_data0 got %h exp %h", ifc.ram_wr_data, model_line(0)); else passed++;
    total++; if (ifc.rxdat_rdy !== 1'b0) $display("FAIL b2b_rdy_write got %b exp 0", ifc.rxdat_rdy); else passed++;
    @(posedge clk); #1;
    done_cyc = cyc;
    total++; if (ifc.linefill_done !== 1'b1 || ifc.linefill_ack_entry_idx !== 4'd1)
      $display("FAIL b2b_done0 got done %b ack %h exp 1 1", ifc.linefill_done, ifc.linefill_ack_entry_idx); else passed++;
    total++; if (ifc.rxdat_rdy !== 1'b0) $display("FAIL b2b_rdy_done got %b exp 0", ifc.rxdat_rdy); else passed++;
    send_line(1, 1'b0, 1'b0, fc1);
    // Accepting edge sits one full cycle after the DONE cycle.
    total++; if (fc1 !== done_cyc + 2) $display("FAIL b2b_first_accept got %0d exp %0d", fc1, done_cyc + 2); else passed++;
    total++; if (ifc.ram_wr_vld !== 1'b1 || ifc.ram_wr_data !== model_line(1))
      $display("FAIL b2b_data1 got vld %b data %h exp %h", ifc.ram_wr_vld, ifc.ram_wr_data, model_line(1)); else passed++;
    total++; if (ifc.ram_wr_index !== m_index[6]) $display("FAIL b2b_index1 got %h exp %h", ifc.ram_wr_index, m_index[6]); else passed++;
    @(posedge clk); #1;
    total++; if (ifc.linefill_done !== 1'b1 || ifc.linefill_ack_entry_idx !== 4'd6)
      $display("FAIL b2b_done1 got done %b ack %h exp 1 6", ifc.linefill_done, ifc.linefill_ack_entry_idx); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_write();
    int fc;
    bit seen_done;
    rand_line(0, 1'b0);
    ifc.ram_wr_rdy = 1'b0;
    send_line(0, 1'b0, 1'b0, fc);
    total++; if (ifc.ram_wr_vld !== 1'b1) $display("FAIL rstw_in_write got %b exp 1", ifc.ram_wr_vld); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ifc.ram_wr_vld !== 1'b0) $display("FAIL rstw_wr_vld got %b exp 0", ifc.ram_wr_vld); else passed++;
    total++; if (ifc.rxdat_rdy !== 1'b1) $display("FAIL rstw_rdy got %b exp 1", ifc.rxdat_rdy); else passed++;
    @(negedge clk);
    rst = 1'b0;
    ifc.ram_wr_rdy = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ifc.linefill_done === 1'b1 || ifc.ram_wr_vld === 1'b1) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) $display("FAIL rstw_dropped got activity %b exp 0", seen_done); else passed++;
    rand_line(0, 1'b0);
    send_line(0, 1'b0, 1'b0, fc);
    total++; if (ifc.ram_wr_vld !== 1'b1 || ifc.ram_wr_data !== model_line(0))
      $display("FAIL rstw_new_line got vld %b data %h exp %h", ifc.ram_wr_vld, ifc.ram_wr_data, model_line(0)); else passed++;
    @(posedge clk); #1;
    total++; if (ifc.linefill_done !== 1'b1 || ifc.linefill_ack_entry_idx !== {1'b0, lid[0]})
      $display("FAIL rstw_new_done got done %b ack %h exp 1 %h", ifc.linefill_done, ifc.linefill_ack_entry_idx, {1'b0, lid[0]}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    int fc, writes;
    rand_line(0, 1'b0);
    ifc.ram_wr_rdy = 1'b1;
    send_line(0, 1'b1, 1'b0, fc);
    total++; if (ifc.ram_wr_vld !== 1'b1 || ifc.ram_wr_data !== model_line(0))
      $display("FAIL gaps_data got vld %b data %h exp %h", ifc.ram_wr_vld, ifc.ram_wr_data, model_line(0)); else passed++;
    writes = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ifc.ram_wr_vld === 1'b1) writes++;
    end
    total++; if (writes !== 1) $display("FAIL gaps_single_write got %0d writes exp 1", writes); else passed++;
  endtask

  task automatic test_random_lines();
    int fc, stall;
    bit gaps;
    for (int n = 0; n < 12; n++) begin
      rand_line(0, 1'b1);
      stall = $urandom_range(0, 3);
      gaps  = 1'($urandom_range(0, 1));
      ifc.ram_wr_rdy = (stall == 0);
      send_line(0, gaps, 1'b0, fc);
      if (model_err(0)) begin
        total++; if (ifc.ram_wr_vld !== 1'b0 || ifc.linefill_done !== 1'b1 || ifc.linefill_err !== 1'b1 || ifc.linefill_ack_entry_idx !== {1'b0, lid[0]})
          $display("FAIL rand_err line %0d got vld %b done %b err %b ack %h exp 0 1 1 %h", n, ifc.ram_wr_vld, ifc.linefill_done, ifc.linefill_err, ifc.linefill_ack_entry_idx, {1'b0, lid[0]});
        else passed++;
      end else begin
        for (int k = 0; k <= stall; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          total++; if (ifc.ram_wr_vld !== 1'b1 || ifc.ram_wr_data !== model_line(0) || ifc.ram_wr_tag !== m_tag[lid[0]] || ifc.ram_wr_way !== m_way[lid[0]])
            $display("FAIL rand_write line %0d cyc %0d got vld %b tag %h way %b exp 1 %h %b (or data)", n, k, ifc.ram_wr_vld, ifc.ram_wr_tag, ifc.ram_wr_way, m_tag[lid[0]], m_way[lid[0]]);
          else passed++;
          if (k == stall) ifc.ram_wr_rdy = 1'b1;
        end
        @(posedge clk); #1;
        total++; if (ifc.linefill_done !== 1'b1 || ifc.linefill_err !== 1'b0 || ifc.linefill_ack_entry_idx !== {1'b0, lid[0]})
          $display("FAIL rand_done line %0d got done %b err %b ack %h exp 1 0 %h", n, ifc.linefill_done, ifc.linefill_err, ifc.linefill_ack_entry_idx, {1'b0, lid[0]});
        else passed++;
      end
      @(posedge clk); #1;
      total++; if (ifc.linefill_done !== 1'b0) $display("FAIL rand_done_pulse line %0d got %b exp 0", n, ifc.linefill_done); else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    rst    = 1'b1;
    ifc.rxdat_vld      = 1'b0;
    ifc.rxdat_entry_id = '0;
    ifc.rxdat_data     = '0;
    ifc.rxdat_err      = 1'b0;
    ifc.ram_wr_rdy     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_index[i] = 7'($urandom);
      m_way[i]   = 1'($urandom);
      m_tag[i]   = 20'($urandom);
    end
    test_reset();
    test_clean_line();
    test_write_stall();
    test_error_line();
    test_back_to_back();
    test_reset_in_write();
    test_gaps();
    test_random_lines();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not complete, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
